// File: rtl/mant_add_pkg.sv
// -----------------------------------------------------------------------------
// mant_add_pkg
// Shared definitions for the mantissa-add arbiter slice:
//   - MANT_W_DEF / N_REQ_DEF : default operand width and requester count
//   - res_state_e            : occupancy of the one-entry result register
//   - id_width()             : requester-index width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package mant_add_pkg;

  localparam int MANT_W_DEF = 11;
  localparam int N_REQ_DEF  = 4;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

  // Index width for n requesters; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin selector: picks the first set bit of i_valid at or
// after position i_ptr, wrapping modulo N_REQ.
// Ports:
//   i_valid [N_REQ-1:0] : request vector
//   i_ptr   [ID_W-1:0]  : highest-priority position (must be < N_REQ)
//   o_grant [N_REQ-1:0] : one-hot grant, zero when nothing is requested
//   o_idx   [ID_W-1:0]  : binary index of the granted requester
//   o_any               : at least one requester is valid
// -----------------------------------------------------------------------------
module rr_grant
  import mant_add_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] w_rot;
  logic [ID_W-1:0]  w_off;
  logic             w_found;
  logic [ID_W:0]    w_sum;

  // Rotate so that the pointer position lands on bit 0; a shift by N_REQ
  // (pointer 0) contributes nothing from the left-shift term.
  assign w_rot = (i_valid >> i_ptr) | (i_valid << (N_REQ - int'(i_ptr)));

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_off   = (w_rot[k] && !w_found) ? ID_W'(k) : w_off;
      w_found = w_found | w_rot[k];
    end
  end

  // Convert the offset back to an absolute index and build the one-hot grant.
  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_W+1)'(N_REQ)) begin
      o_idx = ID_W'(w_sum - (ID_W+1)'(N_REQ));
    end else begin
      o_idx = ID_W'(w_sum);
    end
    if (w_found) begin
      o_grant = N_REQ'(1) << o_idx;
    end else begin
      o_grant = '0;
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/mant_add_arbiter.sv
// -----------------------------------------------------------------------------
// mant_add_arbiter
// Shares one sign-magnitude mantissa adder among N_REQ requesters. A
// round-robin grant selects one requester per cycle, the sum is computed
// combinationally and captured in a one-entry result register one cycle later.
// Requests whose mantissas are both zero can be skipped (zero_skip_en).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   zero_skip_en             : consume all-zero operand pairs without a result
//   req_valid / req_ready    : per-requester handshake, req_ready one-hot or 0
//   req_sign_a/b, req_mant_a/b: per-requester operands, requester i in slice i
//   res_valid / res_ready    : result-register handshake
//   res_id, res_sign, res_mant: owner index and sign-magnitude sum
//   op_count, skip_count     : wrapping 16-bit produced / skipped counters
// -----------------------------------------------------------------------------
module mant_add_arbiter
  import mant_add_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int MANT_W = MANT_W_DEF,
  localparam int ID_W   = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zero_skip_en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_sign_a,
  input  logic [N_REQ-1:0]        req_sign_b,
  input  logic [N_REQ*MANT_W-1:0] req_mant_a,
  input  logic [N_REQ*MANT_W-1:0] req_mant_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_sign,
  output logic [MANT_W:0]         res_mant,
  output logic [15:0]             op_count,
  output logic [15:0]             skip_count
);

  res_state_e       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_res_id;
  logic             r_res_sign;
  logic [MANT_W:0]  r_res_mant;
  logic [15:0]      r_op_count;
  logic [15:0]      r_skip_count;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_can_accept;
  logic             w_take;
  logic             w_skip;
  logic             w_load;
  logic             w_sa;
  logic             w_sb;
  logic [MANT_W-1:0] w_ma;
  logic [MANT_W-1:0] w_mb;
  logic [MANT_W-1:0] w_diff_ab;
  logic [MANT_W-1:0] w_diff_ba;
  logic [MANT_W:0]  w_sum_mant;
  logic             w_sum_sign;
  logic [ID_W:0]    w_ptr_sum;
  logic [ID_W-1:0]  w_ptr_next;

  rr_grant #(
    .N_REQ (N_REQ)
  ) u_rr_grant (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A new operation may enter when the result slot is free or being drained.
  assign w_can_accept = (r_state == ST_EMPTY) || res_ready;
  assign w_take       = w_any & w_can_accept & ~rst;
  assign req_ready    = w_grant & {N_REQ{w_take}};

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    w_ma = '0;
    w_mb = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_sa = w_sa | (req_sign_a[j] & w_grant[j]);
      w_sb = w_sb | (req_sign_b[j] & w_grant[j]);
      w_ma = w_ma | (req_mant_a[j*MANT_W +: MANT_W] & {MANT_W{w_grant[j]}});
      w_mb = w_mb | (req_mant_b[j*MANT_W +: MANT_W] & {MANT_W{w_grant[j]}});
    end
  end

  assign w_skip    = zero_skip_en & (w_ma == '0) & (w_mb == '0);
  assign w_load    = w_take & ~w_skip;
  assign w_diff_ab = w_ma - w_mb;
  assign w_diff_ba = w_mb - w_ma;

  // Sign-magnitude add; an exact cancellation yields +0.
  always_comb begin
    if (w_sa == w_sb) begin
      w_sum_mant = {1'b0, w_ma} + {1'b0, w_mb};
      w_sum_sign = w_sa;
    end else if (w_ma > w_mb) begin
      w_sum_mant = {1'b0, w_diff_ab};
      w_sum_sign = w_sa;
    end else if (w_mb > w_ma) begin
      w_sum_mant = {1'b0, w_diff_ba};
      w_sum_sign = w_sb;
    end else begin
      w_sum_mant = '0;
      w_sum_sign = 1'b0;
    end
  end

  // Pointer moves just past the granted requester, wrapping at N_REQ.
  always_comb begin
    w_ptr_sum = {1'b0, w_idx} + (ID_W+1)'(1);
    if (w_ptr_sum >= (ID_W+1)'(N_REQ)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = ID_W'(w_ptr_sum);
    end
  end

  // Result-register FSM, round-robin pointer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_ptr        <= '0;
      r_res_id     <= '0;
      r_res_sign   <= 1'b0;
      r_res_mant   <= '0;
      r_op_count   <= 16'd0;
      r_skip_count <= 16'd0;
    end else begin
      if (w_take) begin
        r_ptr <= w_ptr_next;
        if (w_skip) begin
          r_skip_count <= r_skip_count + 16'd1;
        end else begin
          r_op_count <= r_op_count + 16'd1;
        end
      end
      if (w_load) begin
        r_res_id   <= w_idx;
        r_res_sign <= w_sum_sign;
        r_res_mant <= w_sum_mant;
      end
      case (r_state)
        ST_EMPTY: r_state <= w_load ? ST_FULL : ST_EMPTY;
        // A skipped grant while draining leaves the slot empty.
        ST_FULL:  r_state <= (w_load || !res_ready) ? ST_FULL : ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign res_valid  = (r_state == ST_FULL);
  assign res_id     = r_res_id;
  assign res_sign   = r_res_sign;
  assign res_mant   = r_res_mant;
  assign op_count   = r_op_count;
  assign skip_count = r_skip_count;

endmodule

// File: tb/tb_mant_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mant_add_arbiter
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model (signed-integer arithmetic, modulo
// pointer search, occupancy flag).
// -----------------------------------------------------------------------------
module tb_mant_add_arbiter;

  localparam int N = 4;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic           zero_skip_en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sign_a;
  logic [N-1:0]   req_sign_b;
  logic [N*W-1:0] req_mant_a;
  logic [N*W-1:0] req_mant_b;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_id;
  logic           res_sign;
  logic [W:0]     res_mant;
  logic [15:0]    op_count;
  logic [15:0]    skip_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_full;
  int   m_id;
  bit   m_sign;
  int   m_mant;
  int   m_ptr;
  int   m_ops;
  int   m_skips;
  bit   e_found;
  int   e_g;
  logic [N-1:0] e_ready;

  always #5 clk = ~clk;

  mant_add_arbiter #(.N_REQ(N), .MANT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .zero_skip_en (zero_skip_en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sign_a   (req_sign_a),
    .req_sign_b   (req_sign_b),
    .req_mant_a   (req_mant_a),
    .req_mant_b   (req_mant_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .res_sign     (res_sign),
    .res_mant     (res_mant),
    .op_count     (op_count),
    .skip_count   (skip_count)
  );

  task automatic set_req(input int i, input bit v, input bit sa, input int ma,
                         input bit sb, input int mb);
    req_valid[i]            = v;
    req_sign_a[i]           = sa;
    req_sign_b[i]           = sb;
    req_mant_a[i*W +: W]    = W'(ma);
    req_mant_b[i*W +: W]    = W'(mb);
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_sign_a   = '0;
    req_sign_b   = '0;
    req_mant_a   = '0;
    req_mant_b   = '0;
    zero_skip_en = 1'b0;
    res_ready    = 1'b0;
  endtask

  function automatic int rand_mant();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 2047;
      2:       return int'($urandom_range(0, 3));
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  // True signed sum of two sign-magnitude values; equal-sign operands keep
  // sign_a even when both are zero.
  function automatic void ref_add(input bit sa, input int ma, input bit sb,
                                  input int mb, output bit rs, output int rm);
    int s;
    s  = (sa ? -ma : ma) + (sb ? -mb : mb);
    rm = (s < 0) ? -s : s;
    rs = (s < 0) || (s == 0 && sa && sb);
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_id = 0; m_sign = 1'b0; m_mant = 0;
    m_ptr = 0; m_ops = 0; m_skips = 0;
  endtask

  task automatic model_eval();
    e_found = 1'b0;
    e_g     = 0;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (!e_found && req_valid[j]) begin
        e_found = 1'b1;
        e_g     = j;
      end
    end
    if (rst || (m_full && !res_ready)) e_found = 1'b0;
    e_ready = e_found ? (N'(1) << e_g) : '0;
  endtask

  task automatic model_update();
    int  ma, mb;
    bit  rs;
    int  rm;
    if (rst) begin
      model_reset();
    end else if (e_found) begin
      m_ptr = (e_g + 1) % N;
      ma = int'(req_mant_a[e_g*W +: W]);
      mb = int'(req_mant_b[e_g*W +: W]);
      if (zero_skip_en && ma == 0 && mb == 0) begin
        m_skips = (m_skips + 1) & 16'hFFFF;
        if (m_full && res_ready) m_full = 1'b0;
      end else begin
        ref_add(req_sign_a[e_g], ma, req_sign_b[e_g], mb, rs, rm);
        m_full = 1'b1; m_id = e_g; m_sign = rs; m_mant = rm;
        m_ops  = (m_ops + 1) & 16'hFFFF;
      end
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: compare against the model shortly after the falling edge,
  // advance through the rising edge, return on the next falling edge.
  task automatic step();
    #1;
    model_eval();
    checks++;
    if (req_ready !== e_ready) begin
      errors++; $display("FAIL model_req_ready: got %b expected %b", req_ready, e_ready);
    end
    checks++;
    if (res_valid !== m_full) begin
      errors++; $display("FAIL model_res_valid: got %b expected %b", res_valid, m_full);
    end
    if (m_full) begin
      checks++;
      if (res_id !== 2'(m_id) || res_sign !== m_sign || res_mant !== 12'(m_mant)) begin
        errors++;
        $display("FAIL model_result: got id=%0d s=%b m=%0d expected id=%0d s=%b m=%0d",
                 res_id, res_sign, res_mant, m_id, m_sign, m_mant);
      end
    end
    checks++;
    if (op_count !== 16'(m_ops) || skip_count !== 16'(m_skips)) begin
      errors++;
      $display("FAIL model_counters: got ops=%0d skips=%0d expected ops=%0d skips=%0d",
               op_count, skip_count, m_ops, m_skips);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i + 1, 1'b0, 3);
    res_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_id !== 2'd0 || res_sign !== 1'b0 || res_mant !== 12'd0) begin
      errors++; $display("FAIL reset_result: got v=%b id=%0d s=%b m=%0d expected all zero",
                         res_valid, res_id, res_sign, res_mant);
    end
    checks++;
    if (op_count !== 16'd0 || skip_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", op_count, skip_count);
    end
  endtask

  task automatic test_round_robin();
    clear_inputs();
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2047)),
                1'($urandom_range(0, 1)), int'($urandom_range(1, 2047)));
      step();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(c % N) || op_count !== 16'(c + 1)) begin
        errors++; $display("FAIL rr_sequence: got v=%b id=%0d ops=%0d expected v=1 id=%0d ops=%0d",
                           res_valid, res_id, op_count, c % N, c + 1);
      end
    end
  endtask

  task automatic test_math();
    clear_inputs();
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 5, 1'b1, 9);
    step();
    checks++;
    if (res_valid !== 1'b1 || res_sign !== 1'b1 || res_mant !== 12'd4) begin
      errors++; $display("FAIL math_diff: got v=%b s=%b m=%0d expected v=1 s=1 m=4",
                         res_valid, res_sign, res_mant);
    end
    set_req(0, 1'b1, 1'b1, 2047, 1'b1, 2047);
    step();
    checks++;
    if (res_sign !== 1'b1 || res_mant !== 12'hFFE) begin
      errors++; $display("FAIL math_max: got s=%b m=%0d expected s=1 m=4094", res_sign, res_mant);
    end
    set_req(0, 1'b1, 1'b0, 7, 1'b1, 7);
    step();
    checks++;
    if (res_valid !== 1'b1 || res_sign !== 1'b0 || res_mant !== 12'd0) begin
      errors++; $display("FAIL math_cancel: got v=%b s=%b m=%0d expected v=1 s=0 m=0",
                         res_valid, res_sign, res_mant);
    end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 3, 1'b0, 4);
    step();
    set_req(0, 1'b0, 1'b0, 0, 1'b0, 0);
    set_req(1, 1'b1, 1'b0, 10, 1'b1, 1);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready_low: got %b expected 0000", req_ready);
      end
      step();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sign !== 1'b0 || res_mant !== 12'd7) begin
        errors++; $display("FAIL bp_hold: got v=%b id=%0d s=%b m=%0d expected v=1 id=0 s=0 m=7",
                           res_valid, res_id, res_sign, res_mant);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_mant !== 12'd9 || res_sign !== 1'b0) begin
      errors++; $display("FAIL bp_new_result: got id=%0d s=%b m=%0d expected id=1 s=0 m=9",
                         res_id, res_sign, res_mant);
    end
  endtask

  task automatic test_skip();
    clear_inputs();
    do_reset();
    res_ready    = 1'b1;
    zero_skip_en = 1'b1;
    set_req(2, 1'b1, 1'b1, 0, 1'b0, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL skip_ready: got %b expected 0100", req_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b0 || skip_count !== 16'd1 || op_count !== 16'd0) begin
      errors++; $display("FAIL skip_effect: got v=%b skips=%0d ops=%0d expected v=0 skips=1 ops=0",
                         res_valid, skip_count, op_count);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i + 1, 1'b0, 1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL skip_ptr: got %b expected 1000", req_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3) begin
      errors++; $display("FAIL skip_next_id: got v=%b id=%0d expected v=1 id=3", res_valid, res_id);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    set_req(0, 1'b1, 1'b0, 6, 1'b0, 6);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || op_count !== 16'd0 || skip_count !== 16'd0) begin
      errors++; $display("FAIL rstmid_state: got v=%b ops=%0d skips=%0d expected 0/0/0",
                         res_valid, op_count, skip_count);
    end
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL idle_no_ready: got %b expected 0000", req_ready);
    end
    step();
    set_req(0, 1'b1, 1'b0, 2, 1'b0, 2);
    set_req(2, 1'b1, 1'b0, 3, 1'b0, 3);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rstmid_grant: got %b expected 0001", req_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_mant !== 12'd4) begin
      errors++; $display("FAIL rstmid_result: got v=%b id=%0d m=%0d expected v=1 id=0 m=4",
                         res_valid, res_id, res_mant);
    end
  endtask

  task automatic test_random();
    int ma;
    clear_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ma = rand_mant();
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ma,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? ma : rand_mant());
      end
      res_ready    = ($urandom_range(0, 3) != 0);
      zero_skip_en = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic test_wrap();
    clear_inputs();
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1, 1'b0, 1);
    for (int c = 0; c < 65537; c++) step();
    checks++;
    if (op_count !== 16'd1) begin
      errors++; $display("FAIL op_wrap: got %0d expected 1", op_count);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_math();
    test_backpressure();
    test_skip();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
